// File: rtl/grant_decoder_pkg.sv
// ---------------------------------------------------------------------------
// grant_decoder_pkg
// Shared scheduler definitions used by the grant decoder and its helpers.
//   state_t   : two-state FSM encoding for the grant path (IDLE, GRANT)
//   widths_ok : elaboration-time sanity check tying the index width to the
//               number of slots
// ---------------------------------------------------------------------------
package grant_decoder_pkg;

    // The grant path is either waiting for an index or holding a grant that
    // the target has not taken yet.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // True when the index width is exactly what is needed to address every
    // slot, and the slot count is one of the supported sizes.
    function automatic bit widths_ok(input int vectorWidth, input int ptrWidth);
        return (ptrWidth == $clog2(vectorWidth)) &&
               ((vectorWidth == 2) || (vectorWidth == 4) ||
                (vectorWidth == 8) || (vectorWidth == 16));
    endfunction

endpackage

// File: rtl/grant_decoder_onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
// Purely combinational index-to-one-hot decoder.
// Ports:
//   i_idx      in   PTR_WIDTH     slot index
//   o_onehot   out  VECTOR_WIDTH  1 << i_idx, all-zero when out of range
//   o_in_range out  1             i_idx addresses an existing slot
// ---------------------------------------------------------------------------
module onehot_decoder
    import grant_decoder_pkg::*;
#(
    parameter int VECTOR_WIDTH = 8,
    parameter int PTR_WIDTH    = 3
) (
    input  logic [PTR_WIDTH-1:0]    i_idx,
    output logic [VECTOR_WIDTH-1:0] o_onehot,
    output logic                    o_in_range
);

    // Compare the index against every slot number rather than shifting, so an
    // index beyond the last slot simply produces an all-zero vector.
    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < VECTOR_WIDTH; k++) begin
            o_onehot[k] = (32'(i_idx) == 32'(k));
        end
    end

    // Only meaningful for configurations where the index can exceed the slot
    // count; with matched widths this is constant true.
    assign o_in_range = (32'(i_idx) < 32'(VECTOR_WIDTH));

endmodule

// File: rtl/grant_decoder.sv
// ---------------------------------------------------------------------------
// grant_decoder
// Turns the scheduler's selected slot index into a registered one-hot grant
// for the per-bank command queues, holds it until acknowledged, and tracks
// which slots still have an outstanding grant so the encoder can mask them.
// Ports:
//   i_clk          in   1               clock, rising edge
//   i_rst          in   1               synchronous active-high reset
//   i_idx          in   PTR_WIDTH       slot index to grant
//   i_valid        in   1               i_idx is valid
//   o_ready        out  1               an index can be accepted this cycle
//   o_grant        out  VECTOR_WIDTH    registered one-hot grant, zero when idle
//   o_grant_valid  out  1               a grant is pending
//   i_grant_ack    in   1               target has taken the current grant
//   i_done         in   VECTOR_WIDTH    per-slot completion pulses
//   o_busy         out  VECTOR_WIDTH    slots with an outstanding grant
//   o_outstanding  out  PTR_WIDTH+1     number of busy slots
//   o_err          out  1               one-cycle pulse for a rejected index
// ---------------------------------------------------------------------------
module grant_decoder
    import grant_decoder_pkg::*;
#(
    parameter int VECTOR_WIDTH = 8,
    parameter int PTR_WIDTH    = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [PTR_WIDTH-1:0]    i_idx,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [VECTOR_WIDTH-1:0] o_grant,
    output logic                    o_grant_valid,
    input  logic                    i_grant_ack,
    input  logic [VECTOR_WIDTH-1:0] i_done,
    output logic [VECTOR_WIDTH-1:0] o_busy,
    output logic [PTR_WIDTH:0]      o_outstanding,
    output logic                    o_err
);

    localparam int CountWidth = PTR_WIDTH + 1;

    // Refuse to elaborate with an index width that cannot address the slots
    // exactly; a mismatch would silently alias or strand slots.
    if (!widths_ok(VECTOR_WIDTH, PTR_WIDTH)) begin : g_bad_widths
        $error("grant_decoder: PTR_WIDTH must equal $clog2(VECTOR_WIDTH) with VECTOR_WIDTH in {2,4,8,16}");
    end

    state_t                  r_state;
    logic [VECTOR_WIDTH-1:0] r_grant;
    logic                    r_grantValid;
    logic [VECTOR_WIDTH-1:0] r_busy;
    logic [CountWidth-1:0]   r_outstanding;
    logic                    r_err;

    logic [VECTOR_WIDTH-1:0] w_onehot;
    logic                    w_inRange;
    logic [VECTOR_WIDTH-1:0] w_effBusy;
    logic                    w_accept;
    logic                    w_legal;
    logic                    w_reject;
    logic [VECTOR_WIDTH-1:0] w_setOnehot;
    logic [VECTOR_WIDTH-1:0] w_busyNext;
    logic [CountWidth-1:0]   w_countNext;

    onehot_decoder #(
        .VECTOR_WIDTH (VECTOR_WIDTH),
        .PTR_WIDTH    (PTR_WIDTH)
    ) u_onehot_decoder (
        .i_idx      (i_idx),
        .o_onehot   (w_onehot),
        .o_in_range (w_inRange)
    );

    // Ready follows the ack combinationally so a new index can be taken in
    // the same cycle the current grant is acknowledged, giving one grant per
    // cycle when the target keeps up.
    assign o_ready = (r_state == IDLE) || ((r_state == GRANT) && i_grant_ack);

    // A slot finishing this cycle is already free for a new grant, so the
    // legality check sees busy with this cycle's done bits removed.
    assign w_effBusy   = r_busy & ~i_done;
    assign w_accept    = i_valid && o_ready;
    assign w_legal     = w_accept && w_inRange && !(|(w_effBusy & w_onehot));
    assign w_reject    = w_accept && !w_legal;
    assign w_setOnehot = w_legal ? w_onehot : '0;
    assign w_busyNext  = w_effBusy | w_setOnehot;

    // Count the slots that will be busy after this edge so the registered
    // count always matches the registered busy vector.
    always_comb begin
        w_countNext = '0;
        for (int k = 0; k < VECTOR_WIDTH; k++) begin
            w_countNext = w_countNext + CountWidth'(w_busyNext[k]);
        end
    end

    // Grant FSM plus busy tracking. A rejected index is consumed without
    // touching grant or busy, but if it arrives alongside an ack the current
    // grant is still released because the target has taken it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grantValid  <= 1'b0;
            r_busy        <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_err         <= w_reject;
            r_busy        <= w_busyNext;
            r_outstanding <= w_countNext;
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_grant      <= w_onehot;
                        r_grantValid <= 1'b1;
                        r_state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (i_grant_ack) begin
                        if (w_legal) begin
                            r_grant      <= w_onehot;
                            r_grantValid <= 1'b1;
                        end else begin
                            r_grant      <= '0;
                            r_grantValid <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end
                end
                default: begin
                    r_grant      <= '0;
                    r_grantValid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = r_grantValid;
    assign o_busy        = r_busy;
    assign o_outstanding = r_outstanding;
    assign o_err         = r_err;

endmodule

// File: tb/tb_grant_decoder.sv
// ---------------------------------------------------------------------------
// tb_grant_decoder
// Runs the grant decoder in an 8-slot and a 16-slot configuration. Each
// configuration has a driver that applies directed and random cycles while a
// slot-level reference model predicts the outputs, and a monitor that pops
// the predictions and compares them with the DUT.
// ---------------------------------------------------------------------------
module tb_grant_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] grant;
        logic        grantValid;
        logic [15:0] busy;
        logic [4:0]  outstanding;
        logic        err;
        logic        ready;
        bit          checkReady;
        string       tag;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    bit instDone [2];

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int VW = (g == 0) ? 8 : 16;
        localparam int PW = (g == 0) ? 3 : 4;

        logic          rst;
        logic          valid;
        logic          ack;
        logic [PW-1:0] idx;
        logic [VW-1:0] done;
        logic          ready;
        logic          grantValid;
        logic          err;
        logic [VW-1:0] grant;
        logic [VW-1:0] busy;
        logic [PW:0]   outstanding;

        grant_decoder #(
            .VECTOR_WIDTH (VW),
            .PTR_WIDTH    (PW)
        ) dut (
            .i_clk         (clk),
            .i_rst         (rst),
            .i_idx         (idx),
            .i_valid       (valid),
            .o_ready       (ready),
            .o_grant       (grant),
            .o_grant_valid (grantValid),
            .i_grant_ack   (ack),
            .i_done        (done),
            .o_busy        (busy),
            .o_outstanding (outstanding),
            .o_err         (err)
        );

        // Reference model: a set of busy slots, the granted slot number
        // (-1 when nothing is granted) and the last-cycle error flag.
        exp_t expQ [$];
        bit   mBusy [16];
        int   mGrant   = -1;
        bit   mErr     = 1'b0;
        bit   mKnown   = 1'b0;
        bit   stimDone = 1'b0;
        string curTag  = "init";

        // Drive one cycle of inputs, record what the DUT should show during
        // this cycle, then advance the model across the coming clock edge.
        task automatic applyStimulus(input logic r, input logic v, input int ix,
                                     input logic a, input logic [15:0] dn);
            exp_t e;
            bit   eff [16];
            bit   accept;
            bit   legal;
            int   cnt;
            @(negedge clk);
            rst   = r;
            valid = v;
            idx   = PW'(ix);
            ack   = a;
            done  = dn[VW-1:0];
            if (mKnown) begin
                e.grant = '0;
                e.busy  = '0;
                cnt     = 0;
                if (mGrant >= 0) e.grant[mGrant] = 1'b1;
                for (int k = 0; k < VW; k++) begin
                    e.busy[k] = mBusy[k];
                    if (mBusy[k]) cnt++;
                end
                e.grantValid  = (mGrant >= 0);
                e.outstanding = 5'(cnt);
                e.err         = mErr;
                e.ready       = (mGrant < 0) || a;
                e.checkReady  = !r;
                e.tag         = curTag;
                expQ.push_back(e);
            end
            if (r) begin
                for (int k = 0; k < 16; k++) mBusy[k] = 1'b0;
                mGrant = -1;
                mErr   = 1'b0;
                mKnown = 1'b1;
            end else if (mKnown) begin
                accept = v && ((mGrant < 0) || a);
                for (int k = 0; k < VW; k++) eff[k] = mBusy[k] && !dn[k];
                legal = accept && (ix < VW) && !eff[ix];
                for (int k = 0; k < VW; k++) mBusy[k] = eff[k];
                if (legal) mBusy[ix] = 1'b1;
                if (legal) mGrant = ix;
                else if ((mGrant >= 0) && a) mGrant = -1;
                mErr = accept && !legal;
            end
        endtask

        task automatic compareOne(input string name, input string tag,
                                  input logic [15:0] actual, input logic [15:0] required);
            checks++;
            if (actual !== required) begin
                failures++;
                $display("[TB] FAIL W=%0d %s/%s: got %h, expected %h at %0t",
                         VW, tag, name, actual, required, $time);
            end
        endtask

        task automatic checkOutput(input exp_t e);
            compareOne("grant",       e.tag, 16'(grant),       e.grant);
            compareOne("grant_valid", e.tag, 16'(grantValid),  16'(e.grantValid));
            compareOne("busy",        e.tag, 16'(busy),        e.busy);
            compareOne("outstanding", e.tag, 16'(outstanding), 16'(e.outstanding));
            compareOne("err",         e.tag, 16'(err),         16'(e.err));
            if (e.checkReady) compareOne("ready", e.tag, 16'(ready), 16'(e.ready));
        endtask

        // Monitor: sample mid-cycle, after the driver has settled this
        // cycle's inputs and well away from the rising edge.
        initial begin : monitor
            exp_t e;
            forever begin
                @(negedge clk);
                #2;
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput(e);
                end else if (stimDone) begin
                    instDone[g] = 1'b1;
                end
            end
        end

        // Driver: directed scenarios first, then random traffic, then a
        // reset taken while a grant is waiting for its ack.
        initial begin : driver
            logic [15:0] edgeDone;
            edgeDone = 16'h0001 | (16'h0001 << (VW - 1));
            rst = 1'b1; valid = 1'b0; idx = '0; ack = 1'b0; done = '0;

            curTag = "reset";
            for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 16'h0);
            curTag = "release";
            applyStimulus(0, 0, 0, 0, 16'h0);

            curTag = "hold5";
            applyStimulus(0, 1, 5, 0, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'h0);
            applyStimulus(0, 0, 0, 1, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'hFFFF);

            curTag = "b2b";
            applyStimulus(0, 1, 1, 0, 16'h0);
            applyStimulus(0, 1, 2, 1, 16'h0);
            applyStimulus(0, 1, 3, 1, 16'h0);
            applyStimulus(0, 0, 0, 1, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'h0);

            curTag = "busyReject";
            applyStimulus(0, 1, 2, 0, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'h0);
            curTag = "doneBypass";
            applyStimulus(0, 1, 2, 0, 16'h0004);
            applyStimulus(0, 0, 0, 0, 16'h0);
            applyStimulus(0, 1, 4, 1, 16'h0);
            applyStimulus(0, 0, 0, 1, 16'hFFFF);

            curTag = "edgeDone";
            applyStimulus(0, 1, 0, 0, 16'h0);
            applyStimulus(0, 1, VW - 1, 1, 16'h0);
            applyStimulus(0, 1, 7, 1, edgeDone);
            applyStimulus(0, 0, 0, 1, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'h0);

            curTag = "random";
            for (int i = 0; i < 400; i++) begin
                applyStimulus(($urandom_range(0, 49) == 0),
                              $urandom_range(0, 1),
                              $urandom_range(0, VW - 1),
                              $urandom_range(0, 1),
                              16'($urandom & $urandom & $urandom));
            end

            curTag = "resetInGrant";
            applyStimulus(0, 0, 0, 1, 16'hFFFF);
            applyStimulus(0, 1, 3, 0, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'h0);
            applyStimulus(1, 0, 0, 0, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'h0);
            applyStimulus(0, 0, 0, 0, 16'h0);
            stimDone = 1'b1;
        end
    end

    // Wait for both configurations to drain, bounded so a stuck run still
    // reports.
    initial begin : summary
        for (int c = 0; c < 5000 && !(instDone[0] && instDone[1]); c++) @(posedge clk);
        if (!(instDone[0] && instDone[1])) begin
            failures++;
            $display("[TB] FAIL timeout: done flags %b%b, expected 11", instDone[1], instDone[0]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
